// File: rtl/decode_stage_hs.sv
// decode_stage_hs: RV32I decode stage with register file, load-use interlock,
// write-through writeback bypass and a main+skid output buffer on valid/ready.
module decode_stage_hs #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          SKID_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_alu_op,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_reg_write,
  output logic            out_use_imm,
  output logic            out_use_pc,
  output logic            out_is_jump,
  output logic            out_is_branch,
  output logic            out_illegal,
  output logic            hazard_stall
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_JALR   = 7'b1100111,
    OPC_SYSTEM = 7'b1110011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_SLL     = 4'd2,
    ALU_SLT     = 4'd3,
    ALU_SLTU    = 4'd4,
    ALU_XOR     = 4'd5,
    ALU_SRL     = 4'd6,
    ALU_SRA     = 4'd7,
    ALU_OR      = 4'd8,
    ALU_AND     = 4'd9,
    ALU_PASSB   = 4'd10,
    ALU_INVALID = 4'd15
  } alu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    alu_op_t         alu_op;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            use_imm;
    logic            use_pc;
    logic            is_jump;
    logic            is_branch;
    logic            illegal;
  } entry_t;

  localparam logic [5:0] NREG = 6'(NUM_REGS);

  // Storage is always 32 deep; entries at or above NUM_REGS are never written.
  logic [XLEN-1:0] rf [32];
  logic            wb_we;

  assign wb_we = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_addr] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] a);
    logic [XLEN-1:0] v;
    if (a == 5'd0 || {1'b0, a} >= NREG) v = '0;
    else if (wb_en && wb_addr == a)     v = wb_data;
    else                                v = rf[a];
    return v;
  endfunction

  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  opcode_t     opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic        rs1_used, rs2_used, rd_used, bad;
  entry_t      dec;

  assign opc   = opcode_t'(in_instr[6:0]);
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    rd_used    = 1'b0;
    bad        = 1'b0;
    imm32      = '0;
    dec.pc     = in_pc;
    dec.funct3 = f3;
    case (opc)
      OPC_OP: begin
        {rs1_used, rs2_used, rd_used, dec.reg_write} = 4'b1111;
        bad        = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'b000 || f3 == 3'b101)));
        dec.alu_op = alu_from_f3(f3, f7[5]);
      end
      OPC_OP_IMM: begin
        {rs1_used, rd_used, dec.reg_write, dec.use_imm} = 4'b1111;
        imm32 = imm_i;
        if (f3 == 3'b001) bad = (f7 != 7'h00);
        if (f3 == 3'b101) bad = (f7 != 7'h00) && (f7 != 7'h20);
        dec.alu_op = alu_from_f3(f3, (f3 == 3'b101) && in_instr[30]);
      end
      OPC_LOAD: begin
        {rs1_used, rd_used, dec.reg_write, dec.use_imm, dec.mem_read} = 5'b11111;
        imm32 = imm_i;
      end
      OPC_JALR: begin
        {rs1_used, rd_used, dec.reg_write, dec.use_imm, dec.is_jump} = 5'b11111;
        imm32 = imm_i;
      end
      OPC_SYSTEM: begin
        {rs1_used, rd_used, dec.use_imm} = 3'b111;
        dec.reg_write = (f3 != 3'b000);
        imm32 = imm_i;
      end
      OPC_STORE: begin
        {rs1_used, rs2_used, dec.use_imm, dec.mem_write} = 4'b1111;
        imm32 = imm_s;
      end
      OPC_BRANCH: begin
        {rs1_used, rs2_used, dec.is_branch} = 3'b111;
        dec.alu_op = ALU_SUB;
        imm32 = imm_b;
      end
      OPC_LUI: begin
        {rd_used, dec.reg_write, dec.use_imm} = 3'b111;
        dec.alu_op = ALU_PASSB;
        imm32 = imm_u;
      end
      OPC_AUIPC: begin
        {rd_used, dec.reg_write, dec.use_imm, dec.use_pc} = 4'b1111;
        imm32 = imm_u;
      end
      OPC_JAL: begin
        {rd_used, dec.reg_write, dec.use_imm, dec.use_pc, dec.is_jump} = 5'b11111;
        imm32 = imm_j;
      end
      default: bad = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    dec.rs1 = rs1_used ? in_instr[19:15] : 5'd0;
    dec.rs2 = rs2_used ? in_instr[24:20] : 5'd0;
    dec.rd  = rd_used  ? in_instr[11:7]  : 5'd0;
    if ((rs1_used && {1'b0, in_instr[19:15]} >= NREG) ||
        (rs2_used && {1'b0, in_instr[24:20]} >= NREG) ||
        (rd_used  && {1'b0, in_instr[11:7]}  >= NREG)) bad = 1'b1;
    if (bad) begin
      dec.illegal   = 1'b1;
      dec.alu_op    = ALU_INVALID;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
    end
    dec.rs1_data = read_reg(dec.rs1);
    dec.rs2_data = read_reg(dec.rs2);
  end

  assign hazard_stall = in_valid & ex_mem_read & (ex_rd != 5'd0) &
                        ((rs1_used & (ex_rd == dec.rs1)) | (rs2_used & (ex_rd == dec.rs2)));

  logic   main_v, skid_v, main_v_n, skid_v_n, accept, drain;
  entry_t main_q, skid_q, main_n, skid_n, main_ref, skid_ref;

  // Unused operand indices are zeroed at decode, so they can never match wb_addr.
  function automatic entry_t refresh(input entry_t e);
    entry_t r;
    r = e;
    if (wb_we && e.rs1 == wb_addr) r.rs1_data = wb_data;
    if (wb_we && e.rs2 == wb_addr) r.rs2_data = wb_data;
    return r;
  endfunction

  assign main_ref = refresh(main_q);
  assign skid_ref = refresh(skid_q);
  assign in_ready = reset & ~hazard_stall & (SKID_EN ? ~skid_v : (~main_v | out_ready));
  assign accept   = in_valid & in_ready;
  assign drain    = main_v & out_ready;

  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    main_n   = main_ref;
    skid_n   = skid_ref;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else begin
      if (drain) begin
        main_n   = skid_ref;
        main_v_n = skid_v;
        skid_v_n = 1'b0;
      end
      if (accept) begin
        if (main_v_n) begin
          skid_n   = dec;
          skid_v_n = 1'b1;
        end else begin
          main_n   = dec;
          main_v_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

  assign out_valid     = main_v;
  assign out_pc        = main_q.pc;
  assign out_rs1_data  = main_q.rs1_data;
  assign out_rs2_data  = main_q.rs2_data;
  assign out_imm       = main_q.imm;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_funct3    = main_q.funct3;
  assign out_alu_op    = main_q.alu_op;
  assign out_mem_read  = main_q.mem_read;
  assign out_mem_write = main_q.mem_write;
  assign out_reg_write = main_q.reg_write;
  assign out_use_imm   = main_q.use_imm;
  assign out_use_pc    = main_q.use_pc;
  assign out_is_jump   = main_q.is_jump;
  assign out_is_branch = main_q.is_branch;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Randomized bench for decode_stage_hs: a queue-based reference model predicts
// the head entry, handshake and interlock each cycle; directed cases pin it.
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, ex_mem_read, wb_en, out_ready;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  ex_rd, wb_addr;

  logic        in_ready, out_valid, hazard_stall;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_op;
  logic        out_mem_read, out_mem_write, out_reg_write, out_use_imm;
  logic        out_use_pc, out_is_jump, out_is_branch, out_illegal;

  logic        e_in_ready, e_out_valid, e_haz, e_mr, e_mw, e_rw, e_ui, e_up, e_j, e_b, e_ill;
  logic [31:0] e_pc, e_r1, e_r2, e_imm;
  logic [4:0]  e_rd, e_rs1, e_rs2;
  logic [2:0]  e_f3;
  logic [3:0]  e_op;

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(32), .NUM_REGS(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_alu_op(out_alu_op), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_use_imm(out_use_imm), .out_use_pc(out_use_pc),
    .out_is_jump(out_is_jump), .out_is_branch(out_is_branch), .out_illegal(out_illegal),
    .hazard_stall(hazard_stall)
  );

  decode_stage_hs #(.XLEN(32), .NUM_REGS(16), .SKID_EN(1'b1)) dut_e (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_pc),
    .out_rs1_data(e_r1), .out_rs2_data(e_r2), .out_imm(e_imm),
    .out_rd(e_rd), .out_rs1(e_rs1), .out_rs2(e_rs2), .out_funct3(e_f3),
    .out_alu_op(e_op), .out_mem_read(e_mr), .out_mem_write(e_mw),
    .out_reg_write(e_rw), .out_use_imm(e_ui), .out_use_pc(e_up),
    .out_is_jump(e_j), .out_is_branch(e_b), .out_illegal(e_ill),
    .hazard_stall(e_haz)
  );

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  op;
    logic        mr, mw, rw, ui, up, jmp, br, ill;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mregs [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode: operation semantics by instruction class.
  function automatic ent_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    ent_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         u1, u2, ud, ok;
    int         base_op [8];
    base_op = '{0, 2, 3, 4, 5, 6, 8, 9};
    e  = '{default: '0};
    f3 = w[14:12];
    f7 = w[31:25];
    u1 = 0; u2 = 0; ud = 0; ok = 1;
    e.pc = pc;
    e.f3 = f3;
    case (w[6:0])
      7'h33: begin
        u1 = 1; u2 = 1; ud = 1; e.rw = 1;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.op = 4'(base_op[f3] + ((f7 == 7'h20) ? 1 : 0));
      end
      7'h13: begin
        u1 = 1; ud = 1; e.rw = 1; e.ui = 1;
        e.imm = 32'($signed(w) >>> 20);
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
        e.op = 4'(base_op[f3] + ((f3 == 5 && w[30]) ? 1 : 0));
      end
      7'h03: begin u1 = 1; ud = 1; e.rw = 1; e.ui = 1; e.mr = 1; e.imm = 32'($signed(w) >>> 20); end
      7'h67: begin u1 = 1; ud = 1; e.rw = 1; e.ui = 1; e.jmp = 1; e.imm = 32'($signed(w) >>> 20); end
      7'h73: begin u1 = 1; ud = 1; e.rw = (f3 != 0); e.ui = 1; e.imm = 32'($signed(w) >>> 20); end
      7'h23: begin u1 = 1; u2 = 1; e.ui = 1; e.mw = 1; e.imm = 32'($signed({w[31:25], w[11:7]})); end
      7'h63: begin
        u1 = 1; u2 = 1; e.br = 1; e.op = 1;
        e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      end
      7'h37: begin ud = 1; e.rw = 1; e.ui = 1; e.op = 10; e.imm = w & 32'hFFFF_F000; end
      7'h17: begin ud = 1; e.rw = 1; e.ui = 1; e.up = 1; e.imm = w & 32'hFFFF_F000; end
      7'h6F: begin
        ud = 1; e.rw = 1; e.ui = 1; e.up = 1; e.jmp = 1;
        e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      end
      default: ok = 0;
    endcase
    e.rs1 = u1 ? w[19:15] : 5'd0;
    e.rs2 = u2 ? w[24:20] : 5'd0;
    e.rd  = ud ? w[11:7]  : 5'd0;
    if (!ok) begin
      e.ill = 1; e.op = 15; e.rw = 0; e.mr = 0; e.mw = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic logic [6:0] pick_f7();
    int r;
    r = $urandom_range(0, 7);
    if (r < 4) return 7'h00;
    if (r < 7) return 7'h20;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] w;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    w   = $urandom;
    case ($urandom_range(0, 10))
      0: w = {pick_f7(), rs2, rs1, f3, rd, 7'h33};
      1: begin
        w = {w[31:20], rs1, f3, rd, 7'h13};
        if (f3 == 3'd1 || f3 == 3'd5) w[31:25] = pick_f7();
      end
      2: w = {w[31:20], rs1, f3, rd, 7'h03};
      3: w = {w[31:20], rs1, 3'b000, rd, 7'h67};
      4: w = {w[31:20], rs1, f3, rd, 7'h73};
      5: w = {w[31:25], rs2, rs1, f3, w[11:7], 7'h23};
      6: w = {w[31:25], rs2, rs1, f3, w[11:7], 7'h63};
      7: w = {w[31:12], rd, 7'h37};
      8: w = {w[31:12], rd, 7'h17};
      9: w = {w[31:12], rd, 7'h6F};
      default: ;
    endcase
    return w;
  endfunction

  task automatic compare_head(input ent_t e);
    chk("out_pc", out_pc, e.pc);
    chk("out_rs1_data", out_rs1_data, e.rs1d);
    chk("out_rs2_data", out_rs2_data, e.rs2d);
    chk("out_imm", out_imm, e.imm);
    chk("out_rd", out_rd, e.rd);
    chk("out_rs1", out_rs1, e.rs1);
    chk("out_rs2", out_rs2, e.rs2);
    chk("out_funct3", out_funct3, e.f3);
    chk("out_alu_op", out_alu_op, e.op);
    chk("out_mem_read", out_mem_read, e.mr);
    chk("out_mem_write", out_mem_write, e.mw);
    chk("out_reg_write", out_reg_write, e.rw);
    chk("out_use_imm", out_use_imm, e.ui);
    chk("out_use_pc", out_use_pc, e.up);
    chk("out_is_jump", out_is_jump, e.jmp);
    chk("out_is_branch", out_is_branch, e.br);
    chk("out_illegal", out_illegal, e.ill);
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    ent_t cur, t;
    bit   haz, exp_rdy, acc, drn;
    #1;
    if (!reset) begin
      q.delete();
      foreach (mregs[i]) mregs[i] = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      return;
    end
    cur      = model_decode(in_instr, in_pc);
    cur.rs1d = mread(cur.rs1);
    cur.rs2d = mread(cur.rs2);
    haz = in_valid && ex_mem_read && ex_rd != 0 && (ex_rd == cur.rs1 || ex_rd == cur.rs2);
    exp_rdy = !haz && q.size() < 2;
    chk("hazard_stall", hazard_stall, haz);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) compare_head(q[0]);
    acc = in_valid && exp_rdy;
    drn = q.size() != 0 && out_ready;
    for (int i = 0; i < q.size(); i++) begin
      t = q[i];
      if (wb_en && wb_addr != 0 && t.rs1 == wb_addr) t.rs1d = wb_data;
      if (wb_en && wb_addr != 0 && t.rs2 == wb_addr) t.rs2d = wb_data;
      q[i] = t;
    end
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; ex_mem_read = 0; ex_rd = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  localparam logic [31:0] ADDI5 = {12'd5, 5'd0, 3'b000, 5'd1, 7'h13};
  localparam logic [31:0] ADDI7 = {12'd7, 5'd0, 3'b000, 5'd2, 7'h13};
  localparam logic [31:0] LUI1  = {20'h12345, 5'd1, 7'h37};
  localparam logic [31:0] SRAI  = {7'h20, 5'd3, 5'd2, 3'b101, 5'd2, 7'h13};
  localparam logic [31:0] BADOP = {25'h0ABCDE, 7'h7F};

  initial begin
    ent_t m;
    reset = 0; out_ready = 0; in_instr = 0; in_pc = 32'h100;
    idle();
    @(negedge clk);
    cycle();
    cycle();
    reset = 1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    m = model_decode(LUI1, 0);
    chk("model_lui_imm", m.imm, 32'h1234_5000);
    chk("model_lui_op", m.op, 10);
    m = model_decode(SRAI, 0);
    chk("model_srai_op", m.op, 7);
    m = model_decode(BADOP, 0);
    chk("model_bad_ill", m.ill, 1);

    // back-pressure: two accepts fill main and skid
    in_valid = 1; in_instr = ADDI5; in_pc = 32'h100; cycle();
    in_instr = ADDI7; in_pc = 32'h104; cycle();
    in_valid = 0;
    #1 chk("bp_in_ready_full", in_ready, 0);
    chk("bp_head_imm", out_imm, 5);
    cycle();
    out_ready = 1; cycle();
    chk("bp_second_imm", out_imm, 7);
    cycle();
    chk("bp_drained", out_valid, 0);

    // load-use interlock
    in_valid = 1; in_instr = {7'h00, 5'd5, 5'd3, 3'b000, 5'd4, 7'h33};
    ex_mem_read = 1; ex_rd = 3;
    #1 chk("lu_stall", hazard_stall, 1);
    chk("lu_in_ready", in_ready, 0);
    cycle();
    ex_mem_read = 0; cycle();
    chk("lu_accepted_rd", out_rd, 4);
    in_valid = 0; cycle();

    // writeback bypass on accept, then refresh of a held entry
    in_valid = 1; in_instr = {7'h20, 5'd0, 5'd6, 3'b000, 5'd7, 7'h33};
    wb_en = 1; wb_addr = 6; wb_data = 32'hDEAD; cycle();
    idle();
    chk("byp_rs1_data", out_rs1_data, 32'hDEAD);
    chk("byp_alu_sub", out_alu_op, 1);
    cycle();
    out_ready = 0; in_valid = 1; in_instr = {7'h00, 5'd6, 5'd1, 3'b000, 5'd8, 7'h33}; cycle();
    idle(); wb_en = 1; wb_addr = 6; wb_data = 32'hBEEF; cycle();
    idle();
    chk("held_rs2_refresh", out_rs2_data, 32'hBEEF);
    out_ready = 1; cycle();

    // flush with both entries full, and flush of a same-cycle accept
    out_ready = 0; in_valid = 1; in_instr = ADDI5; cycle();
    in_instr = ADDI7; cycle();
    flush = 1; cycle();
    idle();
    chk("flush_full", out_valid, 0);
    in_valid = 1; in_instr = ADDI5; flush = 1; cycle();
    idle();
    chk("flush_same_cycle", out_valid, 0);
    cycle();

    // register index range (RV32E instance) and decode coverage
    out_ready = 1; in_valid = 1; in_instr = {12'd1, 5'd0, 3'b000, 5'd20, 7'h13}; cycle();
    chk("rv32e_valid", e_out_valid, 1);
    chk("rv32e_illegal", e_ill, 1);
    chk("rv32e_reg_write", e_rw, 0);
    chk("rv32i_x20_legal", out_illegal, 0);
    in_instr = LUI1; cycle();
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_op", out_alu_op, 10);
    in_instr = SRAI; cycle();
    chk("srai_op", out_alu_op, 7);
    in_instr = BADOP; cycle();
    chk("bad_illegal", out_illegal, 1);
    chk("bad_reg_write", out_reg_write, 0);

    // reset mid-stream with main and skid full
    out_ready = 0; in_instr = ADDI5; cycle();
    in_instr = ADDI7; cycle();
    reset = 0; cycle();
    reset = 1; idle();
    #1 chk("rst_release_ready", in_ready, 1);
    cycle();

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 399) != 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      in_instr    = gen_instr();
      in_pc       = $urandom;
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      wb_en       = 1'($urandom_range(0, 1));
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
